hwag_ckp_gen: RTL and testbench

- Crank position sensor (60-2 trigger wheel) signal generator.
- It is the transmit side of the hwag_core capture/sync path.
- Drives a synthetic 60-2 tooth waveform with a programmable tooth pitch, for closed-loop bench testing of hwag_core (loopback into its cap input) and as an engine simulator output.
- Also outputs the true tooth index and a revolution strobe, so a checker can compare them against hwag_core synchronisation.

---
 rtl/hwag_pkg.sv | 25 ++
 rtl/hwag_ckp_phase.sv | 42 ++++
 rtl/hwag_ckp_gen.sv | 139 +++++++++++++
 tb/tb_hwag_ckp_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// hwag_pkg
// Shared constants and types for the crank-position (60-2 wheel) path.
// Used by the signal generator (hwag_ckp_gen) and by the capture/sync core.
//   PCNT_WIDTH    : width of the tooth period, in clk cycles per tooth pitch
//   TCNT_WIDTH    : width of the tooth index
//   TEETH_TOTAL   : tooth positions per revolution, missing ones included
//   TEETH_MISSING : missing positions, placed at the end of the revolution
//   PERIOD_MIN    : smallest period that is accepted
package hwag_pkg;

    localparam int PCNT_WIDTH    = 24;
    localparam int TCNT_WIDTH    = 6;
    localparam int TEETH_TOTAL   = 60;
    localparam int TEETH_MISSING = 2;
    localparam int PERIOD_MIN    = 4;

    // Number of physically present teeth; positions at or above this are gaps.
    localparam int TEETH_REAL    = TEETH_TOTAL - TEETH_MISSING;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } hwag_state_t;

endpackage

// File: rtl/hwag_ckp_phase.sv
// hwag_ckp_phase
// Phase counter for one tooth pitch of the crank signal generator.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   clear       : hold the counter at 0 (generator idle)
//   period      : active tooth period P currently being counted
//   period_next : period that applies from the next cycle on
//   wrap        : high in the last cycle of a tooth (cnt == P-1)
//   high_next   : the next cycle lies in the high window (cnt_next < P_next/2)
module hwag_ckp_phase
    import hwag_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [PCNT_WIDTH-1:0] period,
    input  logic [PCNT_WIDTH-1:0] period_next,
    output logic                  wrap,
    output logic                  high_next
);

    logic [PCNT_WIDTH-1:0] cnt_reg;
    logic [PCNT_WIDTH-1:0] cnt_next;

    always_comb begin
        wrap      = !clear && (cnt_reg == period - PCNT_WIDTH'(1));
        cnt_next  = (clear || wrap) ? '0 : cnt_reg + PCNT_WIDTH'(1);
        // Compared against the period of the next cycle so that the first
        // cycle of a tooth already uses a freshly loaded period.
        high_next = cnt_next < (period_next >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/hwag_ckp_gen.sv
// hwag_ckp_gen
// Synthetic 60-2 crank position sensor waveform generator with a
// programmable tooth pitch. Teeth are high for floor(P/2) cycles and low for
// the remainder; the missing positions at the end of the revolution stay low.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   ena         : run request, sampled at tooth boundaries while running
//   period_in   : requested tooth pitch in clk cycles
//   period_load : one-cycle strobe writing period_in to the shadow register
//   ckp_out     : generated sensor signal (tooth = high)
//   tooth_num   : current tooth position 0..TEETH_TOTAL-1
//   rev_strobe  : one-cycle pulse with the rising edge of tooth 0
//   running     : generator active
//   load_err    : one-cycle pulse after a rejected load (period_in < PERIOD_MIN)
module hwag_ckp_gen
    import hwag_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PCNT_WIDTH-1:0] period_in,
    input  logic                  period_load,
    output logic                  ckp_out,
    output logic [TCNT_WIDTH-1:0] tooth_num,
    output logic                  rev_strobe,
    output logic                  running,
    output logic                  load_err
);

    hwag_state_t           state_reg, state_next;
    logic [PCNT_WIDTH-1:0] shadow_reg, shadow_next;
    logic [PCNT_WIDTH-1:0] period_reg, period_next;
    logic [TCNT_WIDTH-1:0] idx_reg, idx_next;

    logic                  ckp_reg, ckp_next;
    logic [TCNT_WIDTH-1:0] tooth_reg, tooth_next;
    logic                  strobe_reg, strobe_next;
    logic                  running_reg, running_next;
    logic                  load_err_reg, load_err_next;

    logic                  load_ok;
    logic [PCNT_WIDTH-1:0] eff_period;
    logic                  wrap;
    logic                  high_next;
    logic                  run_next;

    hwag_ckp_phase u_phase (
        .clk         (clk),
        .rst         (rst),
        .clear       (state_reg == ST_IDLE),
        .period      (period_reg),
        .period_next (period_next),
        .wrap        (wrap),
        .high_next   (high_next)
    );

    always_comb begin
        load_ok       = period_load && (period_in >= PCNT_WIDTH'(PERIOD_MIN));
        load_err_next = period_load && !load_ok;
        // A valid load bypasses the shadow register so it can take effect on
        // the very next tooth (or start) without a one-cycle penalty.
        eff_period    = load_ok ? period_in : shadow_reg;
        shadow_next   = eff_period;

        state_next  = state_reg;
        period_next = period_reg;
        idx_next    = idx_reg;

        case (state_reg)
            ST_IDLE: begin
                idx_next = '0;
                if (ena && (eff_period >= PCNT_WIDTH'(PERIOD_MIN))) begin
                    state_next  = ST_RUN;
                    period_next = eff_period;
                end
            end
            ST_RUN: begin
                // ena and the period are only honoured at tooth boundaries,
                // so every tooth is emitted complete.
                if (wrap) begin
                    if (!ena) begin
                        state_next = ST_IDLE;
                        idx_next   = '0;
                    end else begin
                        period_next = eff_period;
                        idx_next    = (idx_reg == TCNT_WIDTH'(TEETH_TOTAL - 1))
                                      ? '0 : idx_reg + TCNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase

        // Outputs are decoded from next-state values and registered, so they
        // line up with the state they describe.
        run_next     = (state_next == ST_RUN);
        running_next = run_next;
        tooth_next   = run_next ? idx_next : '0;
        ckp_next     = run_next && high_next
                       && (idx_next < TCNT_WIDTH'(TEETH_REAL));
        strobe_next  = run_next && (idx_next == '0)
                       && ((state_reg == ST_IDLE) || wrap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shadow_reg   <= '0;
            period_reg   <= '0;
            idx_reg      <= '0;
            ckp_reg      <= 1'b0;
            tooth_reg    <= '0;
            strobe_reg   <= 1'b0;
            running_reg  <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shadow_reg   <= shadow_next;
            period_reg   <= period_next;
            idx_reg      <= idx_next;
            ckp_reg      <= ckp_next;
            tooth_reg    <= tooth_next;
            strobe_reg   <= strobe_next;
            running_reg  <= running_next;
            load_err_reg <= load_err_next;
        end
    end

    assign ckp_out    = ckp_reg;
    assign tooth_num  = tooth_reg;
    assign rev_strobe = strobe_reg;
    assign running    = running_reg;
    assign load_err   = load_err_reg;

endmodule

// File: tb/tb_hwag_ckp_gen.sv
// tb_hwag_ckp_gen
// Self-checking bench for hwag_ckp_gen: a table of start-up vectors, hand
// sequences for revolution timing, period change, stop and reset, then
// randomized stimulus. Every cycle is also compared against a model that
// works from tooth start times and the waveform rules.
module tb_hwag_ckp_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [23:0] period_in = '0;
    logic        period_load = 1'b0;
    logic        ckp_out;
    logic [5:0]  tooth_num;
    logic        rev_strobe;
    logic        running;
    logic        load_err;

    hwag_ckp_gen dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .period_in   (period_in),
        .period_load (period_load),
        .ckp_out     (ckp_out),
        .tooth_num   (tooth_num),
        .rev_strobe  (rev_strobe),
        .running     (running),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: time-stamped tooth starts.
    int cyc = 0;
    bit m_run = 0;
    int m_s = 0;
    int m_p = 0;
    int m_tooth = 0;
    int m_ts = 0;
    bit m_err = 0;

    // Waveform measurements taken from the DUT outputs.
    int rise_cyc [60];
    int hi_cnt [60];
    bit prev_ckp = 0;

    typedef struct {
        logic       r, e, l;
        logic [23:0] p;
        logic       ckp, stb, run, err;
        logic [5:0] tn;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic r, logic e, logic l, logic [23:0] p,
                                logic ckp, logic stb, logic run, logic err,
                                logic [5:0] tn);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.p = p;
        v.ckp = ckp; v.stb = stb; v.run = run; v.err = err; v.tn = tn;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit l, input int p);
        bit valid;
        int eff;
        cyc++;
        if (r) begin
            m_run = 0; m_s = 0; m_p = 0; m_tooth = 0; m_ts = cyc; m_err = 0;
        end else begin
            valid = l && (p >= 4);
            m_err = l && !valid;
            eff = valid ? p : m_s;
            if (!m_run) begin
                if (e && eff >= 4) begin
                    m_run = 1; m_p = eff; m_tooth = 0; m_ts = cyc;
                end
            end else if (cyc - m_ts == m_p) begin
                if (!e) begin
                    m_run = 0;
                end else begin
                    m_p = eff;
                    m_tooth = (m_tooth + 1) % 60;
                    m_ts = cyc;
                end
            end
            if (valid) m_s = p;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int p);
        int pos;
        int expv;
        int act;
        bit e_ckp;
        bit e_stb;
        rst = r; ena = e; period_load = l; period_in = 24'(p);
        @(posedge clk);
        model_edge(r, e, l, p);
        #1;
        pos = cyc - m_ts;
        e_ckp = m_run && (pos < m_p / 2) && (m_tooth < 58);
        e_stb = m_run && (m_tooth == 0) && (pos == 0);
        expv = {22'd0, e_ckp, e_stb, m_run, m_err, (m_run ? 6'(m_tooth) : 6'd0)};
        act  = {22'd0, ckp_out, rev_strobe, running, load_err, tooth_num};
        chk("model{ckp,stb,run,err,tooth}", act, expv);
        if (ckp_out && !prev_ckp) begin
            rise_cyc[tooth_num] = cyc;
            hi_cnt[tooth_num] = 0;
        end
        if (ckp_out) hi_cnt[tooth_num]++;
        prev_ckp = ckp_out;
    endtask

    task automatic run_until_strobe(output int n, output int highs);
        n = 0; highs = 0;
        for (int k = 0; k < 2000; k++) begin
            step(0, 1, 0, 0);
            n++;
            if (ckp_out) highs++;
            if (rev_strobe) return;
        end
        chk("strobe_timeout", 0, 1);
    endtask

    task automatic run_to_tooth(input int t);
        for (int k = 0; k < 3000; k++) begin
            step(0, 1, 0, 0);
            if (running && tooth_num == 6'(t)) return;
        end
        chk("tooth_timeout", t, -1);
    endtask

    initial begin
        int n;
        int h;
        for (int i = 0; i < 60; i++) begin
            rise_cyc[i] = 0; hi_cnt[i] = 0;
        end

        // Start-up table: rst, invalid load, ena with S=0, bypass start at 8.
        tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 3,  0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 8,  1, 1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0,  1, 0, 1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0,  1, 0, 1, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0,  1, 0, 1, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0,  0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0,  0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0,  0, 0, 1, 0, 0);
        tbl[10] = mk(0, 1, 0, 0,  0, 0, 1, 0, 0);
        tbl[11] = mk(0, 1, 0, 0,  1, 0, 1, 0, 1);
        tbl[12] = mk(0, 1, 1, 3,  1, 0, 1, 1, 1);
        tbl[13] = mk(0, 1, 0, 0,  1, 0, 1, 0, 1);
        tbl[14] = mk(1, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 1, 9,  0, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 0,  1, 1, 1, 0, 0);
        tbl[17] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].l, int'(tbl[i].p));
            chk($sformatf("table[%0d]", i),
                int'({ckp_out, rev_strobe, running, load_err, tooth_num}),
                int'({tbl[i].ckp, tbl[i].stb, tbl[i].run, tbl[i].err, tbl[i].tn}));
        end

        // P=8: full revolution, gap spacing and duty.
        step(0, 1, 1, 8);
        run_until_strobe(n, h);
        chk("rev_len_p8", n, 480);
        chk("rev_high_p8", h, 58 * 4);
        chk("gap_rise_p8", rise_cyc[0] - rise_cyc[57], 24);
        chk("tooth57_high_p8", hi_cnt[57], 4);
        $display("seq p8: revolution %0d cycles, %0d high", n, h);

        // P=9: 4 high / 5 low.
        step(0, 1, 1, 9);
        run_until_strobe(n, h);
        run_until_strobe(n, h);
        chk("rev_len_p9", n, 540);
        chk("rev_high_p9", h, 58 * 4);
        chk("gap_rise_p9", rise_cyc[0] - rise_cyc[57], 27);
        $display("seq p9: revolution %0d cycles, %0d high", n, h);

        // Period change mid tooth 10 takes effect from tooth 11.
        step(1, 0, 0, 0);
        step(0, 1, 1, 8);
        run_to_tooth(10);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 16);
        run_to_tooth(12);
        chk("t10_to_t11", rise_cyc[11] - rise_cyc[10], 8);
        chk("t11_to_t12", rise_cyc[12] - rise_cyc[11], 16);
        chk("t10_high", hi_cnt[10], 4);
        chk("t11_high", hi_cnt[11], 8);
        $display("seq load16: tooth10 high %0d, tooth11 high %0d", hi_cnt[10], hi_cnt[11]);

        // Short ena drop ignored; long drop stops at end of tooth 20.
        run_to_tooth(19);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        run_to_tooth(20);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step(0, 0, 0, 0);
            n++;
            if (!running) break;
        end
        chk("stop_latency", n, 16);
        chk("t20_high", hi_cnt[20], 8);
        chk("stopped_ckp", int'(ckp_out), 0);
        step(0, 1, 0, 0);
        chk("restart", int'({ckp_out, rev_strobe, running, tooth_num}), int'({3'b111, 6'd0}));
        $display("seq stop: stopped after %0d cycles, restart tooth %0d", n, tooth_num);

        // Reset in the gap.
        run_to_tooth(58);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_in_gap", int'({ckp_out, rev_strobe, running, load_err, tooth_num}), 0);
        step(0, 1, 0, 0);
        chk("rst_clears_shadow", int'(running), 0);
        $display("seq rst: outputs cleared, running %0d", running);

        // Randomized stimulus against the model.
        for (int k = 0; k < 4000; k++) begin
            bit r;
            bit e;
            bit l;
            int p;
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 99) < 97);
            l = ($urandom_range(0, 49) == 0);
            p = int'($urandom_range(0, 12));
            step(r, e, l, p);
        end
        $display("seq random: 4000 cycles done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
